// File: rtl/proyecto_fsm.sv
// Three chained Moore FSMs: power/fault supervisor, mode selector with run grant, step sequencer.
// Optional fault tracking is enabled by defining PROYECTO_FSM_FAULT_EN.
module proyecto_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       S,
  input  logic       T,
  input  logic       H,
  input  logic [1:0] P,
  input  logic       R,
  input  logic       J,
  input  logic       B,
  output logic       I,
  output logic       E0,
  output logic       F,
  output logic       K,
  output logic [2:0] E1,
  output logic [2:0] M1,
  output logic       G,
  output logic       V,
  output logic [2:0] E2,
  output logic [2:0] M2,
  output logic       A,
  output logic       E3
);

  typedef enum logic [2:0] {
    F2_IDLE = 3'b000,
    F2_WAIT = 3'b001,
    F2_MA   = 3'b010,
    F2_MB   = 3'b011,
    F2_MC   = 3'b100,
    F2_RUN  = 3'b101,
    F2_DONE = 3'b110,
    F2_BAD  = 3'b111
  } fsm2_e;

  typedef enum logic [2:0] {
    F3_IDLE = 3'b000,
    F3_ARM  = 3'b001,
    F3_ST1  = 3'b010,
    F3_ST2  = 3'b011,
    F3_ST3  = 3'b100,
    F3_FIN  = 3'b101,
    F3_BAD6 = 3'b110,
    F3_BAD7 = 3'b111
  } fsm3_e;

  logic       e0_q, e0_d;
  logic       f_q, f_d;
  fsm2_e      s2_q, s2_d;
  fsm3_e      s3_q, s3_d;
  logic [2:0] mode_q, mode_d;

  logic k_int, g_int, a_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q   <= 1'b0;
      f_q    <= 1'b0;
      s2_q   <= F2_IDLE;
      s3_q   <= F3_IDLE;
      mode_q <= 3'b000;
    end else begin
      e0_q   <= e0_d;
      f_q    <= f_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      mode_q <= mode_d;
    end
  end

  // Handshake signals between the machines are decoded from registered state only.
  assign k_int = e0_q & ~f_q;
  assign g_int = (s2_q == F2_RUN);
  assign a_int = (s3_q == F3_FIN);

  always_comb begin
    e0_d = e0_q;
    if (!e0_q && S && T && H) begin
      e0_d = 1'b1;
    end else if (e0_q && !S) begin
      e0_d = 1'b0;
    end
  end

`ifdef PROYECTO_FSM_FAULT_EN
  // Dropping S clears the fault even if the interlock trips on the same clock.
  always_comb begin
    f_d = f_q;
    if (!S) begin
      f_d = 1'b0;
    end else if (e0_q && !H) begin
      f_d = 1'b1;
    end
  end
`else
  always_comb begin
    f_d = 1'b0;
  end
`endif

  always_comb begin
    s2_d   = s2_q;
    mode_d = mode_q;
    case (s2_q)
      F2_IDLE: s2_d = F2_WAIT;
      F2_WAIT: begin
        case (P)
          2'b01:   s2_d = F2_MA;
          2'b10:   s2_d = F2_MB;
          2'b11:   s2_d = F2_MC;
          default: s2_d = F2_WAIT;
        endcase
      end
      F2_MA, F2_MB, F2_MC: begin
        // Latch the mode code so it survives into RUN and DONE.
        mode_d = (s2_q == F2_MA) ? 3'b001 : (s2_q == F2_MB) ? 3'b010 : 3'b100;
        if (R && J) begin
          s2_d = F2_RUN;
        end else if (R) begin
          s2_d = F2_WAIT;
        end
      end
      F2_RUN:  if (a_int) s2_d = F2_DONE;
      F2_DONE: if (!R && !J) s2_d = F2_WAIT;
      default: s2_d = F2_IDLE;
    endcase
    if (!k_int) begin
      s2_d = F2_IDLE;
    end
  end

  always_comb begin
    s3_d = s3_q;
    case (s3_q)
      F3_IDLE: if (g_int) s3_d = F3_ARM;
      F3_ARM, F3_ST1, F3_ST2, F3_ST3: begin
        if (!g_int) begin
          s3_d = F3_IDLE;
        end else if (B) begin
          s3_d = fsm3_e'(s3_q + 3'd1);
        end
      end
      F3_FIN:  if (!g_int) s3_d = F3_IDLE;
      default: s3_d = F3_IDLE;
    endcase
  end

  always_comb begin
    case (s2_q)
      F2_MA:           M1 = 3'b001;
      F2_MB:           M1 = 3'b010;
      F2_MC:           M1 = 3'b100;
      F2_RUN, F2_DONE: M1 = mode_q;
      default:         M1 = 3'b000;
    endcase
  end

  always_comb begin
    case (s3_q)
      F3_ST1:  M2 = 3'b001;
      F3_ST2:  M2 = 3'b010;
      F3_ST3:  M2 = 3'b011;
      F3_FIN:  M2 = 3'b100;
      default: M2 = 3'b000;
    endcase
  end

  assign I  = e0_q;
  assign E0 = e0_q;
  assign F  = f_q;
  assign K  = k_int;
  assign E1 = s2_q;
  assign G  = g_int;
  assign V  = (s2_q == F2_MA) || (s2_q == F2_MB) || (s2_q == F2_MC) || (s2_q == F2_RUN);
  assign E2 = s3_q;
  assign A  = a_int;
  assign E3 = (s3_q == F3_ARM) || (s3_q == F3_ST1) || (s3_q == F3_ST2) || (s3_q == F3_ST3);

endmodule

// File: tb/tb_proyecto_fsm.sv
// Scoreboard bench for proyecto_fsm: directed scenarios then randomized stimulus against a phase/step model.
module tb_proyecto_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       S = 1'b0, T = 1'b0, H = 1'b0, R = 1'b0, J = 1'b0, B = 1'b0;
  logic [1:0] P = 2'b00;
  logic       I, E0, F, K, G, V, A, E3;
  logic [2:0] E1, M1, E2, M2;

  proyecto_fsm dut (
    .clk(clk), .rst_n(rst_n), .S(S), .T(T), .H(H), .P(P), .R(R), .J(J), .B(B),
    .I(I), .E0(E0), .F(F), .K(K), .E1(E1), .M1(M1), .G(G), .V(V),
    .E2(E2), .M2(M2), .A(A), .E3(E3)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_out;
  assign dut_out = {E0, F, K, I, E1, M1, G, V, E2, M2, A, E3};

  // Model: power flag, fault flag, coarse phase of the mode machine, chosen mode code,
  // and sequencer position (-1 = not engaged, 0 = armed, 1..3 = steps, 4 = finished).
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SEL = 2, PH_RUN = 3, PH_DONE = 4;
  int m_on, m_fault, m_phase, m_sel, m_step;

  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic logic [19:0] model_out();
    int e1, m1, e2, m2;
    logic on, flt, k, g, v, a, e3;
    case (m_phase)
      PH_IDLE: e1 = 0;
      PH_WAIT: e1 = 1;
      PH_SEL:  e1 = (m_sel == 1) ? 2 : (m_sel == 2) ? 3 : 4;
      PH_RUN:  e1 = 5;
      default: e1 = 6;
    endcase
    m1  = (m_phase >= PH_SEL) ? m_sel : 0;
    e2  = (m_step < 0) ? 0 : m_step + 1;
    m2  = (m_step <= 0) ? 0 : m_step;
    on  = (m_on != 0);
    flt = (m_fault != 0);
    k   = on && !flt;
    g   = (m_phase == PH_RUN);
    v   = (m_phase == PH_SEL) || (m_phase == PH_RUN);
    a   = (m_step == 4);
    e3  = (m_step >= 0) && (m_step <= 3);
    return {on, flt, k, on, e1[2:0], m1[2:0], g, v, e2[2:0], m2[2:0], a, e3};
  endfunction

  task automatic model_reset();
    m_on = 0; m_fault = 0; m_phase = PH_IDLE; m_sel = 0; m_step = -1;
  endtask

  task automatic model_step(input bit s, t, h, input bit [1:0] p, input bit r, j, b);
    int n_on, n_fault, n_phase, n_sel, n_step;
    bit k, g, a;
    k = (m_on != 0) && (m_fault == 0);
    g = (m_phase == PH_RUN);
    a = (m_step == 4);
    n_on = (m_on != 0) ? int'(s) : int'(s && t && h);
`ifdef PROYECTO_FSM_FAULT_EN
    n_fault = !s ? 0 : ((m_fault != 0) || ((m_on != 0) && !h)) ? 1 : 0;
`else
    n_fault = 0;
`endif
    n_phase = m_phase;
    n_sel = m_sel;
    if (!k) n_phase = PH_IDLE;
    else begin
      case (m_phase)
        PH_IDLE: n_phase = PH_WAIT;
        PH_WAIT: if (p != 0) begin n_phase = PH_SEL; n_sel = 1 << (int'(p) - 1); end
        PH_SEL:  if (r && j) n_phase = PH_RUN; else if (r) n_phase = PH_WAIT;
        PH_RUN:  if (a) n_phase = PH_DONE;
        default: if (!r && !j) n_phase = PH_WAIT;
      endcase
    end
    n_step = m_step;
    if (m_step < 0) begin
      if (g) n_step = 0;
    end else if (!g) n_step = -1;
    else if (m_step < 4 && b) n_step = m_step + 1;
    m_on = n_on; m_fault = n_fault; m_phase = n_phase; m_sel = n_sel; m_step = n_step;
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic drive(input bit rst, input bit s, t, h, input bit [1:0] p, input bit r, j, b);
    @(negedge clk);
    S = s; T = t; H = h; P = p; R = r; J = j; B = b;
    if (rst) begin
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_out !== 20'h0) begin
        n_fail++;
        $display("FAIL async_reset got=%05h exp=00000", dut_out);
      end
      model_reset();
    end else begin
      rst_n = 1'b1;
      model_step(s, t, h, p, r, j, b);
    end
    exp_q.push_back(model_out());
  endtask

  initial begin : monitor
    logic [19:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (dut_out !== exp_v) begin
          n_fail++;
          $display("FAIL cycle %0d outputs got=%05h exp=%05h", cyc, dut_out, exp_v);
        end else begin
          $display("cycle %0d outputs %05h ok", cyc, dut_out);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    #1;
    n_checks++;
    if (dut_out !== 20'h0) begin
      n_fail++;
      $display("FAIL initial_reset got=%05h exp=00000", dut_out);
    end
    drive(1, 1, 1, 1, 2'b11, 1, 1, 1);
    // Nominal power-up, mode A, run, four steps, done, release.
    drive(0, 1, 1, 1, 2'b00, 0, 0, 0);
    drive(0, 1, 0, 1, 2'b00, 0, 0, 1);
    drive(0, 1, 0, 1, 2'b00, 0, 0, 1);
    drive(0, 1, 0, 1, 2'b01, 0, 0, 0);
    drive(0, 1, 0, 1, 2'b10, 1, 1, 0);
    drive(0, 1, 0, 1, 2'b00, 1, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 2'b00, 1, 1, 1);
    drive(0, 1, 0, 1, 2'b00, 1, 1, 0);
    drive(0, 1, 0, 1, 2'b00, 0, 0, 0);
    drive(0, 1, 0, 1, 2'b00, 0, 0, 0);
    // Mode B cancelled by run request without confirm.
    drive(0, 1, 0, 1, 2'b10, 0, 0, 0);
    drive(0, 1, 0, 1, 2'b00, 1, 0, 0);
    drive(0, 1, 0, 1, 2'b00, 0, 0, 0);
    // Mode C run, abort by dropping S during the sequence.
    drive(0, 1, 0, 1, 2'b11, 0, 0, 0);
    drive(0, 1, 0, 1, 2'b00, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 2'b00, 1, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 2'b00, 1, 1, 1);
    // Interlock drop while on, recovery, then S off.
    drive(0, 1, 1, 1, 2'b00, 0, 0, 0);
    drive(0, 1, 0, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 2'b01, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 2'b01, 0, 0, 0);
    drive(0, 0, 0, 1, 2'b00, 0, 0, 0);
    drive(0, 0, 0, 1, 2'b00, 0, 0, 0);
    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 31) != 0, 1'($urandom),
            $urandom_range(0, 15) != 0, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
